// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: pin synchronisers, clock glitch filter, falling-edge
// detector and an 11-bit frame assembler (start, 8 data LSB-first, odd parity,
// stop) with a watchdog for truncated frames.
// Optional feature macro: PS2_PARITY_CHECK_EN (defined = parity verified,
// err_code 10 possible; undefined = parity bit sampled but ignored).
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err_tick,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic                  c_s1_q, c_s2_q, d_s1_q, d_s2_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fc_q, fc_d;
  logic                  fall_q, fall_d;
  logic [7:0]            sreg_q, sreg_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  par_q, par_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic [7:0]            dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic                  start_ok;
  logic                  wd_hit;
  logic                  timeout;
  logic                  par_ok;

  // Two-flop synchronisers for both pins, idle-high after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_s1_q <= 1'b1;
      c_s2_q <= 1'b1;
      d_s1_q <= 1'b1;
      d_s2_q <= 1'b1;
    end else begin
      c_s1_q <= ps2c;
      c_s2_q <= c_s1_q;
      d_s1_q <= ps2d;
      d_s2_q <= d_s1_q;
    end
  end

  // Glitch filter: fc only changes after FILTER_LEN equal samples; fall is a
  // registered pulse that lines up with fc dropping.
  always_comb begin
    filt_d = {filt_q[FILTER_LEN-2:0], c_s2_q};
    fc_d   = fc_q;
    if (filt_q == '0) begin
      fc_d = 1'b0;
    end else if (&filt_q) begin
      fc_d = 1'b1;
    end
    fall_d = fc_q & ~fc_d;
  end

  // Filter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= '1;
      fc_q   <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      fc_q   <= fc_d;
      fall_q <= fall_d;
    end
  end

  assign start_ok = fall_q & rx_en & ~d_s2_q;
  // Compare against TIMEOUT_CYC-2 so the registered tick lands exactly
  // TIMEOUT_CYC cycles after the last fall pulse.
  assign wd_hit   = (wd_q == WdW'(TIMEOUT_CYC - 2));
  assign timeout  = (state_q != StIdle) & ~fall_q & wd_hit;
  assign par_ok   = ^{sreg_q, par_q};

`ifndef PS2_PARITY_CHECK_EN
  logic unused_par_ok;
  assign unused_par_ok = par_ok;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; the watchdog overrides any in-frame state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = StData;
      StData:   if (fall_q && bit_cnt_q == 3'd7) state_d = StParity;
      StParity: if (fall_q) state_d = StStop;
      StStop:   if (fall_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (timeout) state_d = StIdle;
  end

  // Datapath next-state: shift register, counters, result and tick flops.
  always_comb begin
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    dout_d    = dout_q;
    code_d    = code_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wd_d      = (state_q == StIdle || fall_q) ? '0 : wd_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start_ok) bit_cnt_d = 3'd0;
      end
      StData: begin
        if (fall_q) begin
          sreg_d    = {d_s2_q, sreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      StParity: begin
        if (fall_q) par_d = d_s2_q;
      end
      StStop: begin
        if (fall_q) begin
          if (!d_s2_q) begin
            err_d  = 1'b1;
            code_d = 2'b01;
`ifdef PS2_PARITY_CHECK_EN
          end else if (!par_ok) begin
            err_d  = 1'b1;
            code_d = 2'b10;
`endif
          end else begin
            done_d = 1'b1;
            dout_d = sreg_q;
            code_d = 2'b00;
          end
        end
      end
      default: ;
    endcase
    if (timeout) begin
      err_d  = 1'b1;
      code_d = 2'b11;
    end
  end

  // Datapath register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      wd_q      <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      wd_q      <= wd_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  // Outputs: busy follows the FSM, everything else is registered.
  always_comb begin
    busy           = (state_q != StIdle);
    dout           = dout_q;
    rx_done_tick   = done_q;
    frame_err_tick = err_q;
    err_code       = code_q;
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: frames are driven on the pins, the
// expected outcome of each is queued and the tick monitor pops and compares.
module tb_ps2_rx_frame;

  localparam int unsigned FL = 8;
  localparam int unsigned TO = 400;
  localparam int HP = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err_tick;
  logic [1:0] err_code;
  logic       busy;

  typedef struct packed {
    logic       is_err;
    logic [7:0] dout;
    logic [1:0] code;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         tick_cnt = 0;
  int         cyc = 0;
  int         last_fall_cyc = 0;
  int         last_tick_cyc = 0;
  logic [7:0] model_dout = 8'h00;

  ps2_rx_frame #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2c          (ps2c),
    .ps2d          (ps2d),
    .rx_en         (rx_en),
    .dout          (dout),
    .rx_done_tick  (rx_done_tick),
    .frame_err_tick(frame_err_tick),
    .err_code      (err_code),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick monitor: every tick must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && (rx_done_tick || frame_err_tick)) begin
      tick_cnt++;
      last_tick_cyc = cyc;
      total++;
      if (rx_done_tick && frame_err_tick) begin
        bad++;
        $display("FAIL tick_exclusive: both ticks high at cycle %0d", cyc);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tick: done=%0b err=%0b code=%b, none expected",
                 rx_done_tick, frame_err_tick, err_code);
      end else begin
        e = sb.pop_front();
        if (frame_err_tick !== e.is_err) begin
          bad++;
          $display("FAIL tick_kind: err_tick=%0b, expected %0b", frame_err_tick, e.is_err);
        end
        total++;
        if (dout !== e.dout) begin
          bad++;
          $display("FAIL tick_dout: dout=%h, expected %h", dout, e.dout);
        end
        total++;
        if (err_code !== e.code) begin
          bad++;
          $display("FAIL tick_code: err_code=%b, expected %b", err_code, e.code);
        end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_flip,
                                           input logic stop);
    return {stop, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  // Drives the first nbits of a frame; glitch adds a 3-cycle low pulse in the
  // high phase of every data/parity/stop bit.
  task automatic send_frame(input logic [10:0] f, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      if (glitch && i > 0) begin
        wait_n(10);
        ps2c = 1'b0;
        wait_n(3);
        ps2c = 1'b1;
        wait_n(12);
      end else begin
        wait_n(25);
      end
      ps2c = 1'b0;
      last_fall_cyc = cyc;
      wait_n(HP);
      ps2c = 1'b1;
      wait_n(25);
    end
    ps2d = 1'b1;
  endtask

  task automatic expect_good(input logic [7:0] d);
    sb.push_back({1'b0, d, 2'b00});
    model_dout = d;
  endtask

  task automatic expect_err(input logic [1:0] code);
    sb.push_back({1'b1, model_dout, code});
  endtask

  task automatic test_reset;
    reset = 1'b0;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    wait_n(5);
    total++;
    if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: %h vs 00", dout); end
    total++;
    if (rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done: %b vs 0", rx_done_tick); end
    total++;
    if (frame_err_tick !== 1'b0) begin
      bad++; $display("FAIL reset_err: %b vs 0", frame_err_tick);
    end
    total++;
    if (err_code !== 2'b00) begin bad++; $display("FAIL reset_code: %b vs 00", err_code); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: %b vs 0", busy); end
    reset = 1'b1;
    wait_n(20);
  endtask

  task automatic test_single;
    expect_good(8'h1C);
    send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL single_missing: %0d pending, expected 0", sb.size()); sb.delete();
    end
    wait_n(5);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: %b vs 0", busy); end
    total++;
    if (dout !== 8'h1C) begin bad++; $display("FAIL single_dout: %h vs 1c", dout); end
    total++;
    if (err_code !== 2'b00) begin bad++; $display("FAIL single_code: %b vs 00", err_code); end
  endtask

  task automatic test_back_to_back;
    expect_good(8'hF0);
    expect_good(8'h1C);
    send_frame(mk_frame(8'hF0, 1'b0, 1'b1), 11, 1'b0);
    wait_n(20);
    send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL b2b_missing: %0d pending, expected 0", sb.size()); sb.delete();
    end
    wait_n(20);
  endtask

  task automatic test_parity;
`ifdef PS2_PARITY_CHECK_EN
    expect_err(2'b10);
`else
    expect_good(8'h3B);
`endif
    send_frame(mk_frame(8'h3B, 1'b1, 1'b1), 11, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL parity_missing: %0d pending, expected 0", sb.size()); sb.delete();
    end
    wait_n(5);
    total++;
    if (dout !== model_dout) begin
      bad++; $display("FAIL parity_dout: %h vs %h", dout, model_dout);
    end
    wait_n(15);
  endtask

  task automatic test_stop_err;
    expect_err(2'b01);
    send_frame(mk_frame(8'h21, 1'b0, 1'b0), 11, 1'b0);
    wait_n(20);
    expect_err(2'b01);
    send_frame(mk_frame(8'h21, 1'b1, 1'b0), 11, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL stop_missing: %0d pending, expected 0", sb.size()); sb.delete();
    end
    wait_n(20);
  endtask

  task automatic test_timeout;
    int t0;
    int waited;
    expect_err(2'b11);
    t0 = tick_cnt;
    send_frame(mk_frame(8'h77, 1'b0, 1'b1), 5, 1'b0);
    waited = 0;
    while (tick_cnt == t0 && waited < int'(TO) + 100) begin
      wait_n(1);
      waited++;
    end
    total++;
    if (tick_cnt == t0) begin
      bad++; $display("FAIL timeout_tick: no tick within %0d cycles", waited); sb.delete();
    end
    total++;
    if (last_tick_cyc != last_fall_cyc + int'(FL) + 3 + int'(TO)) begin
      bad++;
      $display("FAIL timeout_latency: tick at %0d, expected %0d", last_tick_cyc,
               last_fall_cyc + int'(FL) + 3 + int'(TO));
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: %b vs 0", busy); end
    wait_n(20);
    expect_good(8'h5A);
    send_frame(mk_frame(8'h5A, 1'b0, 1'b1), 11, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL timeout_next: %0d pending, expected 0", sb.size()); sb.delete();
    end
    wait_n(20);
  endtask

  task automatic test_glitch;
    expect_good(8'hA7);
    send_frame(mk_frame(8'hA7, 1'b0, 1'b1), 11, 1'b1);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL glitch_missing: %0d pending, expected 0", sb.size()); sb.delete();
    end
    wait_n(20);
  endtask

  task automatic test_rx_en;
    int t0;
    t0 = tick_cnt;
    rx_en = 1'b0;
    send_frame(mk_frame(8'h42, 1'b0, 1'b1), 11, 1'b0);
    rx_en = 1'b1;
    wait_n(20);
    total++;
    if (tick_cnt != t0) begin
      bad++; $display("FAIL rxen_ignored: %0d ticks, expected 0", tick_cnt - t0);
    end
    // Dropping rx_en mid-frame must not abort the frame.
    expect_good(8'h42);
    fork
      send_frame(mk_frame(8'h42, 1'b0, 1'b1), 11, 1'b0);
      begin
        wait_n(300);
        rx_en = 1'b0;
      end
    join
    rx_en = 1'b1;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL rxen_drop: %0d pending, expected 0", sb.size()); sb.delete();
    end
    wait_n(20);
  endtask

  task automatic test_reset_mid;
    send_frame(mk_frame(8'h99, 1'b0, 1'b1), 6, 1'b0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_hi: %b vs 1", busy); end
    reset = 1'b0;
    model_dout = 8'h00;
    wait_n(3);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_lo: %b vs 0", busy); end
    total++;
    if (dout !== 8'h00) begin bad++; $display("FAIL mid_dout: %h vs 00", dout); end
    reset = 1'b1;
    wait_n(500);
    expect_good(8'h66);
    send_frame(mk_frame(8'h66, 1'b0, 1'b1), 11, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL mid_next: %0d pending, expected 0", sb.size()); sb.delete();
    end
    wait_n(5);
    total++;
    if (dout !== 8'h66) begin bad++; $display("FAIL mid_next_dout: %h vs 66", dout); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_stop_err();
    test_timeout();
    test_glitch();
    test_rx_en();
    test_reset_mid();
    wait_n(20);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL final_pending: %0d pending, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

PS/2 receive front end: synchronises and de-glitches the raw `ps2c`/`ps2d` pins, detects falling clock edges, and assembles each 11-bit device frame (start, 8 data LSB-first, odd parity, stop) into a byte. It sits directly between the board pins and the scan-code decoder inside `Circuito_total`. It delivers one `rx_done_tick` per good frame and one `frame_err_tick` per rejected frame. A watchdog recovers from truncated frames.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive equal samples of synchronised `ps2c` required before the filtered clock changes (2..16).
- `TIMEOUT_CYC`, 20000: max `clk` cycles between falling edges inside a frame before abort (≥ 4·FILTER_LEN).

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `ps2c` in 1: raw PS/2 clock pin, asynchronous.
- `ps2d` in 1: raw PS/2 data pin, asynchronous.
- `rx_en` in 1: 1 = a new frame may start; gates only the start bit.
- `dout` out 8: last good byte; held until next good frame.
- `rx_done_tick` out 1: one-cycle pulse, `dout` valid on the same cycle.
- `frame_err_tick` out 1: one-cycle pulse on rejected frame.
- `err_code` out 2: 01 stop error, 10 parity error, 11 timeout; held until next tick of either kind.
- `busy` out 1: high from start-bit acceptance to end of frame.

## Operation
- Input path: `ps2c`, `ps2d` each through 2-flop synchroniser. Synchronised clock shifts into a `FILTER_LEN`-bit register; filtered clock `fc` goes 0 when register all-0, 1 when all-1, else holds.
- `fall` = registered one-cycle pulse when `fc` goes 1→0. Data sampled = synchronised `ps2d` on the `fall` cycle.
- FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: on `fall` with `rx_en`=1 and data=0 → DATA, bit counter=0, `busy`=1. Data=1 or `rx_en`=0: ignore, stay.
  - DATA: each `fall` shifts data into bit 7 of shift reg (right shift, LSB first); after 8th → PARITY.
  - PARITY: `fall` captures parity bit → STOP.
  - STOP: `fall`: if stop=1 and parity OK → load `dout`, pulse `rx_done_tick`; else pulse `frame_err_tick` with code (stop error wins over parity). Either way → IDLE, `busy`=0.
- Parity OK ⇔ XOR of 8 data bits and parity bit = 1 (odd).
- Watchdog: counter clears on every `fall`, increments otherwise while not IDLE; reaching `TIMEOUT_CYC` → IDLE, `frame_err_tick`, `err_code`=11. Stuck-low `ps2c` in IDLE does not time out.
- `rx_en` dropping mid-frame does not abort; frame completes normally.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `frame_err_tick`=0, `err_code`=00, `busy`=0, FSM IDLE, filter reg all-1, `fc`=1, sync flops 1.
- Pin fall to `fall` pulse: 2 (sync) + `FILTER_LEN` + 1 cycles (11 at default); pulses < `FILTER_LEN` cycles rejected.
- `rx_done_tick`/`frame_err_tick`: registered, cycle after the stop-bit `fall`; mutually exclusive; never back-to-back faster than one frame.
- `busy` rises cycle after start-bit `fall`, falls with the done/err tick.
- Reset asserted mid-frame: immediate IDLE, partial byte discarded, no tick on release.
- Timeout tick fires exactly `TIMEOUT_CYC` cycles after the last `fall`.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: parity verified as above, code 10 possible.
- Not defined: parity bit sampled but ignored; any frame with stop=1 is good; `err_code` never 10.

## Test plan
- Byte 0x1C (frame LSB-first: 0,00111000,0,1), ps2c half-period 50 cycles → one `rx_done_tick`, `dout`=0x1C, `err_code`=00, `busy` low after.
- Sequence 0xF0 then 0x1C back-to-back → two ticks, `dout`=0xF0 then 0x1C, no err.
- 0x1C with parity bit 1 → `frame_err_tick`, `err_code`=10, `dout` unchanged (with macro); without macro → `rx_done_tick`, `dout`=0x1C.
- Stop bit 0 → `frame_err_tick`, `err_code`=01. Stop bit 0 plus bad parity → still 01.
- Stop ps2c after 4 data bits → after `TIMEOUT_CYC` cycles `frame_err_tick`, `err_code`=11; following good 0x5A frame received correctly.
- 3-cycle ps2c glitches during DATA → no extra bits, byte correct; `rx_en`=0 at start → frame ignored; reset pulsed mid-frame → no tick, next frame OK.
